// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder/subtractor: adds one DIGIT-bit slice per
// clock, LSB digit first, and publishes Sum/Cout/Overflow with a one-cycle done.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned SUM_W = DIGIT + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_c;

  // Current digit sum; the new slice enters the accumulator from the top so
  // after NDIG steps the accumulator holds the whole result in place.
  always_comb begin
    slice_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + SUM_W'(carry);
    acc_next  = (acc >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // On the last digit the low slice bits hold the operand MSBs: signed
    // overflow when both operands share a sign that the result does not.
    ovf_c     = (a_sh[DIGIT-1] == b_sh[DIGIT-1]) && (slice_sum[DIGIT-1] != a_sh[DIGIT-1]);
  end

  // Control FSM and datapath registers; outputs only change on load or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= Sub ? ~B : B;
            carry <= Cin ^ Sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          acc   <= acc_next;
          carry <= slice_sum[DIGIT];
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            Sum      <= acc_next;
            Cout     <= slice_sum[DIGIT];
            Overflow <= ovf_c;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed corner cases plus random operations on
// a 16/4 instance, and exhaustive 4-bit sweeps on DIGIT=1 and DIGIT=4 instances.
module tb_digit_serial_adder;

  logic clk;
  logic rst;

  logic        start16, cin16, sub16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic       start4, cin4, sub4;
  logic [3:0] a4, b4;
  logic       busy4a, done4a, cout4a, ovf4a;
  logic [3:0] sum4a;
  logic       busy4b, done4b, cout4b, ovf4b;
  logic [3:0] sum4b;

  int n_tests;
  int n_fail;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .Cin(cin16), .Sub(sub16),
    .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16), .Overflow(ovf16)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4a (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4), .Sub(sub4),
    .busy(busy4a), .done(done4a), .Sum(sum4a), .Cout(cout4a), .Overflow(ovf4a)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut4b (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4), .Sub(sub4),
    .busy(busy4b), .done(done4b), .Sum(sum4b), .Cout(cout4b), .Overflow(ovf4b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: unsigned sum for Sum/Cout, signed range test for Overflow.
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit cin, input bit sub,
                                output longint unsigned s, output bit co, output bit ov);
    longint unsigned rng, mask, bp, full;
    longint          half, sa, sb, ss;
    bit              c;
    rng  = 64'd1 << w;
    mask = rng - 1;
    half = longint'(rng >> 1);
    bp   = sub ? (~b & mask) : (b & mask);
    c    = cin ^ sub;
    full = a + bp + longint'(c);
    s    = full & mask;
    co   = ((full >> w) & 1) != 0;
    sa   = (longint'(a) >= half) ? longint'(a) - longint'(rng) : longint'(a);
    sb   = (longint'(bp) >= half) ? longint'(bp) - longint'(rng) : longint'(bp);
    ss   = sa + sb + longint'(c);
    ov   = (ss > half - 1) || (ss < -half);
  endfunction

  // One 16-bit operation, called at a falling edge; returns at a falling edge.
  // Inputs are scrambled and start is re-pulsed mid-run: neither may matter.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit cin,
                       input bit sub, input string tag);
    longint unsigned es;
    bit              ec, eo, held;
    int              lat;
    logic [17:0]     prev;
    model(16, a, b, cin, sub, es, ec, eo);
    prev    = {sum16, cout16, ovf16};
    a16     = a;
    b16     = b;
    cin16   = cin;
    sub16   = sub;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    check({tag, "_busy_start"}, busy16, 1);
    a16   = 16'($urandom);
    b16   = 16'($urandom);
    cin16 = 1'($urandom);
    sub16 = 1'($urandom);
    lat   = -1;
    held  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      if (done16) begin
        lat = k;
        break;
      end
      if ({sum16, cout16, ovf16} !== prev || busy16 !== 1'b1) held = 1'b0;
    end
    check({tag, "_latency"}, 64'(lat), 4);
    check({tag, "_hold_during_run"}, held, 1);
    check({tag, "_sum"}, sum16, es);
    check({tag, "_cout"}, cout16, ec);
    check({tag, "_ovf"}, ovf16, eo);
    check({tag, "_busy_done"}, busy16, 1);
    @(negedge clk);
    check({tag, "_idle_flags"}, {busy16, done16}, 0);
    check({tag, "_sum_hold"}, sum16, es);
  endtask

  // One 4-bit operation on both narrow instances at once.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit cin, input bit sub);
    longint unsigned es;
    bit              ec, eo;
    int              lat_a, lat_b;
    logic [5:0]      res_a, res_b;
    model(4, a, b, cin, sub, es, ec, eo);
    a4     = a;
    b4     = b;
    cin4   = cin;
    sub4   = sub;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat_a  = -1;
    lat_b  = -1;
    res_a  = '0;
    res_b  = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done4a && lat_a < 0) begin
        lat_a = k;
        res_a = {sum4a, cout4a, ovf4a};
      end
      if (done4b && lat_b < 0) begin
        lat_b = k;
        res_b = {sum4b, cout4b, ovf4b};
      end
      if (lat_a >= 0 && lat_b >= 0) break;
    end
    check("w4d1_latency", 64'(lat_a), 4);
    check("w4d4_latency", 64'(lat_b), 1);
    check("w4d1_result", res_a, {es[3:0], ec, eo});
    check("w4d4_result", res_b, {es[3:0], ec, eo});
    @(negedge clk);
    check("w4_idle", {busy4a, busy4b, done4a, done4b}, 0);
  endtask

  initial begin
    int n_done;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; sub4  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset16_outputs", {busy16, done16, sum16, cout16, ovf16}, 0);
    check("reset4_outputs", {busy4a, done4a, sum4a, cout4a, ovf4a,
                             busy4b, done4b, sum4b, cout4b, ovf4b}, 0);
    rst = 1'b0;

    // Directed corner cases
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
    run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "add_cin");
    run16(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_neg");
    run16(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");

    // No queued operation after a mid-run start pulse
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done16 || busy16) n_done++;
    end
    check("no_queued_op", 64'(n_done), 0);

    // Reset during RUN digit 2 aborts with cleared outputs and no done
    run16(16'h1234, 16'h4321, 1'b1, 1'b0, "pre_abort");
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0; sub16 = 1'b0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {busy16, done16, sum16, cout16, ovf16}, 0);
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done16) n_done++;
    end
    check("abort_no_done", 64'(n_done), 0);

    // Reset with start waiting: the first edge after release accepts it
    rst = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    check("rst_over_start", busy16, 0);
    rst = 1'b0;
    run16(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, "post_reset");

    // Random 16-bit operations
    for (int i = 0; i < 150; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand16");
    end

    // Exhaustive 4-bit sweep on both digit sizes
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++)
            run4(4'(a), 4'(b), 1'(c), 1'(s));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
